nmr_bstrm_capture: RTL

// Capture-side counterpart of the bitstream player: samples a BUS_WIDTH bitstream bus (GPIO loopback of the

---
 rtl/nmr_bstrm_capture.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nmr_bstrm_capture.sv
// Bitstream capture: samples the loopback bus and streams it into a FIFO.
// Arms on START, begins on first non-zero word, ends on marker+tail, STOP or limit.
module nmr_bstrm_capture #(
  parameter int BUS_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TAIL_WORDS = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [CNT_WIDTH-1:0] MAX_WORDS,
  input  logic [BUS_WIDTH-1:0] bitstr_in,
  input  logic                 fifo_full,
  output logic [BUS_WIDTH-1:0] fifo_data,
  output logic                 fifo_wrreq,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVERFLOW,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPT,
    S_TAIL,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TAIL_N = CNT_WIDTH'(TAIL_WORDS);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  state_t               state;
  logic [BUS_WIDTH-1:0] bus_q;
  logic [CNT_WIDTH-1:0] max_q;
  logic [CNT_WIDTH-1:0] tail_cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 wr_ok;
  logic                 lim_hit;
  logic                 marker;
  logic                 bus_nz;

  // Limit only advances on words that actually reach the FIFO.
  always_comb begin
    wr_ok   = !fifo_full;
    cnt_inc = (&word_cnt) ? word_cnt : word_cnt + ONE;
    lim_hit = wr_ok && (max_q != '0) && (cnt_inc == max_q);
    marker  = bus_q[BUS_WIDTH-1];
    bus_nz  = |bus_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      bus_q      <= '0;
      max_q      <= '0;
      tail_cnt   <= '0;
      fifo_data  <= '0;
      fifo_wrreq <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      OVERFLOW   <= 1'b0;
      word_cnt   <= '0;
    end else begin
      bus_q      <= bitstr_in;
      fifo_wrreq <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            state    <= S_ARM;
            BUSY     <= 1'b1;
            word_cnt <= '0;
            OVERFLOW <= 1'b0;
            max_q    <= MAX_WORDS;
          end
        end
        S_ARM, S_CAPT: begin
          if (STOP) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else if (state == S_CAPT || bus_nz) begin
            if (wr_ok) begin
              fifo_data  <= bus_q;
              fifo_wrreq <= 1'b1;
              word_cnt   <= cnt_inc;
            end else begin
              OVERFLOW <= 1'b1;
            end
            if (lim_hit || (marker && TAIL_WORDS == 0)) begin
              state <= S_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else if (marker) begin
              state    <= S_TAIL;
              tail_cnt <= TAIL_N;
            end else begin
              state <= S_CAPT;
            end
          end
        end
        S_TAIL: begin
          if (STOP) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            if (wr_ok) begin
              fifo_data  <= bus_q;
              fifo_wrreq <= 1'b1;
              word_cnt   <= cnt_inc;
            end else begin
              OVERFLOW <= 1'b1;
            end
            tail_cnt <= tail_cnt - ONE;
            if (tail_cnt == ONE || lim_hit) begin
              state <= S_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!START) begin
            state <= S_IDLE;
            DONE  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
